fetch_buffer: RTL and testbench

- Responder side of the fetch-address interface: consumes the PC driven by the IF stage, issues it to a synchronous (1-cycle latency) instruction memory, and captures each returned word with its PC into a small FIFO.
- Decode pops the FIFO with a valid/ready handshake.
- Back-pressures IF via pc_stall; flushes all queued and in-flight fetches on a redirect (pc_sel).

---
 rtl/fetch_buffer.sv | 85 ++++++++
 tb/tb_fetch_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues the IF-stage PC to a 1-cycle synchronous instruction memory and
// queues each returned word with its PC in a small FIFO for decode.
module fetch_buffer #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_val,
  input  logic              pc_sel,
  output logic              pc_stall,
  output logic              imem_en,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic [DWIDTH-1:0] imem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_pc,
  output logic [DWIDTH-1:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] inst_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              inflight;
  logic [AWIDTH-1:0] inflight_pc;
  logic [PW+1:0]     occupancy;
  logic              push;
  logic              pop;

  // Occupancy counts the in-flight read so a returning word always has a free slot.
  // A same-cycle pop is deliberately ignored: no out_ready -> pc_stall path.
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign pc_stall  = (occupancy >= DEPTH_W);
  assign imem_en   = !rst && !pc_stall && !pc_sel;
  assign imem_addr = pc_val;

  // Handshake: the head entry transfers on a rising edge when out_valid && out_ready;
  // out_pc/out_inst hold stable while out_valid && !out_ready.
  assign out_valid = (count != '0) && !pc_sel;
  assign out_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
  assign out_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;

  assign push = inflight && !pc_sel;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (pc_sel) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) inflight_pc <= pc_val;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates the outputs until an entry is written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= inflight_pc;
      inst_mem[wr_ptr] <= imem_dout;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: IF and imem models, a queue-based reference of issued-but-unconsumed
// PCs checked every cycle, and directed plus randomized scenarios.
module tb_fetch_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC_VAL = 32'h4000_0000;
  localparam logic [DW-1:0] INST_XOR = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_val;
  logic [AW-1:0] pc_new_val = '0;
  logic          pc_sel = 1'b0;
  logic          pc_stall;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] exp_q[$];
  int            iss_q[$];
  logic [AW-1:0] got_pc[$];
  logic [DW-1:0] got_inst[$];
  int            got_cyc[$];
  int            first_en;

  bit            m_stall, m_en, m_valid;
  logic [AW-1:0] m_pc;

  // clock and reset
  always #5 clk = ~clk;

  fetch_buffer #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_val(pc_val), .pc_sel(pc_sel), .pc_stall(pc_stall),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  // IF stage: redirect wins over stall, otherwise advance by one instruction
  always @(posedge clk or posedge rst) begin
    if (rst)            pc_val <= RESET_PC_VAL;
    else if (pc_sel)    pc_val <= pc_new_val;
    else if (!pc_stall) pc_val <= pc_val + 32'd4;
  end

  always @(posedge clk) begin
    if (imem_en) imem_dout <= imem_addr ^ INST_XOR;
  end

  // Scoreboard: exp_q holds every PC issued since the last flush/reset and not yet consumed.
  // Its size is exactly what must be buffered or in flight; an entry becomes visible two
  // cycles after issue.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || imem_en !== 1'b0 || pc_stall !== 1'b0 ||
          out_pc !== '0 || out_inst !== '0) begin
        errors++;
        $display("FAIL mon_reset_outputs: valid=%b en=%b stall=%b pc=%h inst=%h, required all zero",
                 out_valid, imem_en, pc_stall, out_pc, out_inst);
      end
      exp_q.delete();
      iss_q.delete();
    end else begin
      m_stall = (exp_q.size() >= DEPTH);
      m_en    = !m_stall && !pc_sel;
      m_valid = !pc_sel && (exp_q.size() > 0) && (iss_q[0] + 2 <= cyc);
      checks++;
      if ({pc_stall, imem_en, out_valid} !== {m_stall, m_en, m_valid}) begin
        errors++;
        $display("FAIL mon_flags cyc %0d: stall/en/valid=%b%b%b required %b%b%b",
                 cyc, pc_stall, imem_en, out_valid, m_stall, m_en, m_valid);
      end
      checks++;
      if (exp_q.size() > DEPTH) begin
        errors++;
        $display("FAIL mon_count_bound cyc %0d: occupancy %0d required <= %0d", cyc, exp_q.size(), DEPTH);
      end
      if (m_valid && out_ready) begin
        m_pc = exp_q.pop_front();
        void'(iss_q.pop_front());
        checks++;
        if (out_pc !== m_pc || out_inst !== (m_pc ^ INST_XOR)) begin
          errors++;
          $display("FAIL mon_pop cyc %0d: pc=%h inst=%h required pc=%h inst=%h",
                   cyc, out_pc, out_inst, m_pc, m_pc ^ INST_XOR);
        end
      end
      if (pc_sel) begin
        exp_q.delete();
        iss_q.delete();
      end else if (m_en) begin
        exp_q.push_back(pc_val);
        iss_q.push_back(cyc);
      end
    end
    cyc++;
  end

  // driver tasks: every task starts and returns just after a falling edge
  task automatic apply_reset(input logic ready);
    rst = 1'b1;
    pc_sel = 1'b0;
    pc_new_val = '0;
    out_ready = ready;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collect_pops(input int n, input int budget, input bit toggle);
    got_pc.delete();
    got_inst.delete();
    got_cyc.delete();
    first_en = -1;
    for (int i = 0; i < budget && got_pc.size() < n; i++) begin
      if (toggle) out_ready = ~out_ready;
      #4;
      if (imem_en && first_en < 0) first_en = i;
      if (out_valid && out_ready) begin
        got_pc.push_back(out_pc);
        got_inst.push_back(out_inst);
        got_cyc.push_back(i);
      end
      @(negedge clk);
    end
    while (got_pc.size() < n) begin
      got_pc.push_back('x);
      got_inst.push_back('x);
      got_cyc.push_back(-100);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++;
    if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b required 0", imem_en); end
    checks++;
    if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", pc_stall); end
    checks++;
    if (out_pc !== '0 || out_inst !== '0) begin
      errors++; $display("FAIL reset_head: pc=%h inst=%h required 0/0", out_pc, out_inst);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fetch;
    out_ready = 1'b1;
    rst = 1'b0;
    collect_pops(3, 20, 1'b0);
    checks++;
    if (got_pc[0] !== RESET_PC_VAL || got_inst[0] !== 32'hBFFF_0000) begin
      errors++; $display("FAIL first_pop: pc=%h inst=%h required 40000000/bfff0000", got_pc[0], got_inst[0]);
    end
    checks++;
    if (got_cyc[0] - first_en !== 2) begin
      errors++; $display("FAIL first_latency: got %0d cycles required 2", got_cyc[0] - first_en);
    end
    checks++;
    if (got_pc[1] !== RESET_PC_VAL + 32'd4 || got_pc[2] !== RESET_PC_VAL + 32'd8) begin
      errors++; $display("FAIL first_seq: got %h %h required 40000004 40000008", got_pc[1], got_pc[2]);
    end
    checks++;
    if (got_cyc[2] - got_cyc[0] !== 2) begin
      errors++; $display("FAIL first_rate: got %0d cycles for 3 pops required 2", got_cyc[2] - got_cyc[0]);
    end
  endtask

  task automatic test_backpressure;
    apply_reset(1'b0);
    repeat (12) @(negedge clk);
    #4;
    checks++;
    if (pc_stall !== 1'b1 || imem_en !== 1'b0) begin
      errors++; $display("FAIL bp_stall: stall=%b en=%b required 1/0", pc_stall, imem_en);
    end
    checks++;
    if (pc_val !== RESET_PC_VAL + 32'h10) begin
      errors++; $display("FAIL bp_pc_frozen: got %h required %h", pc_val, RESET_PC_VAL + 32'h10);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC_VAL) begin
      errors++; $display("FAIL bp_head: valid=%b pc=%h required 1/%h", out_valid, out_pc, RESET_PC_VAL);
    end
    @(negedge clk);
    out_ready = 1'b1;
    collect_pops(5, 20, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_pc[k] !== RESET_PC_VAL + 32'(4 * k)) begin
        errors++; $display("FAIL bp_order[%0d]: got %h required %h", k, got_pc[k], RESET_PC_VAL + 32'(4 * k));
      end
    end
  endtask

  task automatic test_flush;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    pc_sel = 1'b1;
    pc_new_val = 32'h2000_0000;
    #4;
    checks++;
    if (pc_stall !== 1'b1 || out_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: stall=%b valid=%b en=%b required 1/0/0", pc_stall, out_valid, imem_en);
    end
    @(negedge clk);
    pc_sel = 1'b0;
    #4;
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b1 || pc_val !== 32'h2000_0000) begin
      errors++; $display("FAIL flush_after: valid=%b en=%b pc=%h required 0/1/20000000", out_valid, imem_en, pc_val);
    end
    @(negedge clk);
    out_ready = 1'b1;
    collect_pops(4, 20, 1'b0);
    checks++;
    if (got_pc[0] !== 32'h2000_0000 || got_inst[0] !== 32'hDFFF_0000) begin
      errors++; $display("FAIL flush_first: pc=%h inst=%h required 20000000/dfff0000", got_pc[0], got_inst[0]);
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (got_pc[k] !== 32'h2000_0000 + 32'(4 * k)) begin
        errors++; $display("FAIL flush_seq[%0d]: got %h required %h", k, got_pc[k], 32'h2000_0000 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_back_to_back;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    collect_pops(14, 80, 1'b1);
    out_ready = 1'b1;
    checks++;
    if (got_pc[0] !== RESET_PC_VAL) begin
      errors++; $display("FAIL b2b_first: got %h required %h", got_pc[0], RESET_PC_VAL);
    end
    for (int k = 1; k < 14; k++) begin
      checks++;
      if (got_pc[k] !== got_pc[k-1] + 32'd4) begin
        errors++; $display("FAIL b2b_step[%0d]: got %h required %h", k, got_pc[k], got_pc[k-1] + 32'd4);
      end
    end
  endtask

  task automatic test_async_reset;
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_before: valid=%b required 1", out_valid); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || imem_en !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: valid=%b pc=%h en=%b required 0/0/0", out_valid, out_pc, imem_en);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    collect_pops(2, 20, 1'b0);
    checks++;
    if (got_pc[0] !== RESET_PC_VAL || got_pc[1] !== RESET_PC_VAL + 32'd4) begin
      errors++; $display("FAIL arst_first: got %h %h required %h %h", got_pc[0], got_pc[1],
                         RESET_PC_VAL, RESET_PC_VAL + 32'd4);
    end
  endtask

  task automatic test_stalled_redirect;
    logic [AW-1:0] target;
    target = 32'h3000_0000 | (32'($urandom_range(0, 255)) << 2);
    apply_reset(1'b0);
    repeat (6) @(negedge clk);
    pc_sel = 1'b1;
    pc_new_val = target;
    #4;
    checks++;
    if (pc_stall !== 1'b1 || out_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++; $display("FAIL sredir_cycle: stall=%b valid=%b en=%b required 1/0/0", pc_stall, out_valid, imem_en);
    end
    @(negedge clk);
    pc_sel = 1'b0;
    #4;
    checks++;
    if (pc_stall !== 1'b0 || out_valid !== 1'b0 || pc_val !== target) begin
      errors++; $display("FAIL sredir_after: stall=%b valid=%b pc=%h required 0/0/%h", pc_stall, out_valid, pc_val, target);
    end
    @(negedge clk);
    out_ready = 1'b1;
    collect_pops(2, 20, 1'b0);
    checks++;
    if (got_pc[0] !== target || got_inst[0] !== (target ^ INST_XOR)) begin
      errors++; $display("FAIL sredir_first: pc=%h inst=%h required %h/%h", got_pc[0], got_inst[0], target, target ^ INST_XOR);
    end
  endtask

  task automatic test_random;
    int pops;
    pops = 0;
    apply_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      out_ready = (i < 200) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      pc_sel = ($urandom_range(0, 15) == 0);
      if (pc_sel) pc_new_val = $urandom & 32'hFFFF_FFFC;
      #4;
      if (out_valid && out_ready) pops++;
      @(negedge clk);
    end
    pc_sel = 1'b0;
    checks++;
    if (pops < 40) begin
      errors++; $display("FAIL random_throughput: got %0d pops required >= 40", pops);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_stalled_redirect();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
